// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module      : writeback_regfile
// Description : RV32I writeback result select, 32-entry integer register file
//               with two combinational read ports, write-through bypass and a
//               registered copy of x10 (a0).
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_regfile #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteW,
    input  logic [1:0]            ResultSrcW,
    input  logic [WIDTH-1:0]      ReadDataW,
    input  logic [WIDTH-1:0]      ALUResultW,
    input  logic [WIDTH-1:0]      PCPlus4W,
    input  logic [WIDTH-1:0]      ImmExtW,
    input  logic [ADDR_WIDTH-1:0] RdW,
    input  logic [ADDR_WIDTH-1:0] A1D,
    input  logic [ADDR_WIDTH-1:0] A2D,
    output logic [WIDTH-1:0]      RD1D,
    output logic [WIDTH-1:0]      RD2D,
    output logic [WIDTH-1:0]      ResultW,
    output logic [WIDTH-1:0]      a0
);

    localparam int                    c_NUM_REGS = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_ZERO_IDX = '0;
    localparam logic [ADDR_WIDTH-1:0] c_A0_IDX   = ADDR_WIDTH'(10);

    localparam logic [1:0] c_SRC_ALU = 2'b00;
    localparam logic [1:0] c_SRC_MEM = 2'b01;
    localparam logic [1:0] c_SRC_PC4 = 2'b10;
    localparam logic [1:0] c_SRC_IMM = 2'b11;

    logic [WIDTH-1:0] w_result;
    logic             w_wr_en;
    logic [WIDTH-1:0] r_regs [c_NUM_REGS];
    logic [WIDTH-1:0] r_a0;

    always_comb begin
        w_result = ALUResultW;
        case (ResultSrcW)
            c_SRC_ALU: w_result = ALUResultW;
            c_SRC_MEM: w_result = ReadDataW;
            c_SRC_PC4: w_result = PCPlus4W;
            c_SRC_IMM: w_result = ImmExtW;
            default:   w_result = ALUResultW;
        endcase
    end

    assign w_wr_en = RegWriteW && (RdW != c_ZERO_IDX);

    // x0 has no storage; its slot is tied to zero so reads need no special case.
    assign r_regs[0] = '0;

    for (genvar g = 1; g < c_NUM_REGS; g++) begin : g_reg
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_regs[g] <= '0;
            end else if (w_wr_en && (RdW == ADDR_WIDTH'(g))) begin
                r_regs[g] <= w_result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a0 <= '0;
        end else if (w_wr_en && (RdW == c_A0_IDX)) begin
            r_a0 <= w_result;
        end
    end

    // Bypass lets decode see the value committed on this same edge.
    always_comb begin
        RD1D = r_regs[A1D];
        RD2D = r_regs[A2D];
        if (w_wr_en && (RdW == A1D)) RD1D = w_result;
        if (w_wr_en && (RdW == A2D)) RD2D = w_result;
    end

    assign ResultW = w_result;
    assign a0      = r_a0;

endmodule
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_regfile
// Description : Directed self-checking bench for writeback_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_regfile;

    logic        clk;
    logic        rst;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [31:0] ReadDataW, ALUResultW, PCPlus4W, ImmExtW;
    logic [4:0]  RdW, A1D, A2D;
    logic [31:0] RD1D, RD2D, ResultW, a0;

    int tests;
    int fails;

    writeback_regfile #(.WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteW  (RegWriteW),
        .ResultSrcW (ResultSrcW),
        .ReadDataW  (ReadDataW),
        .ALUResultW (ALUResultW),
        .PCPlus4W   (PCPlus4W),
        .ImmExtW    (ImmExtW),
        .RdW        (RdW),
        .A1D        (A1D),
        .A2D        (A2D),
        .RD1D       (RD1D),
        .RD2D       (RD2D),
        .ResultW    (ResultW),
        .a0         (a0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; checks happen #1 later or #1 after a rising edge.
    task automatic test_reset();
        rst = 1'b0;
        RegWriteW = 1'b1; RdW = 5'd5; ResultSrcW = 2'b00; ALUResultW = 32'hDEADBEEF;
        ReadDataW = 32'h0; PCPlus4W = 32'h0; ImmExtW = 32'h0;
        A1D = 5'd5; A2D = 5'd6;
        @(negedge clk); #1;
        tests++; if (a0 !== 32'h0) begin fails++; $display("FAIL reset_a0 got %h expected %h", a0, 32'h0); end
        tests++; if (RD2D !== 32'h0) begin fails++; $display("FAIL reset_rd2 got %h expected %h", RD2D, 32'h0); end
        tests++; if (RD1D !== 32'hDEADBEEF) begin fails++; $display("FAIL reset_bypass got %h expected %h", RD1D, 32'hDEADBEEF); end
        @(posedge clk); #1;
        tests++; if (a0 !== 32'h0) begin fails++; $display("FAIL reset_a0_edge got %h expected %h", a0, 32'h0); end
        @(negedge clk);
        rst = 1'b1; RegWriteW = 1'b0;
        #1;
        tests++; if (RD1D !== 32'h0) begin fails++; $display("FAIL reset_write_lost got %h expected %h", RD1D, 32'h0); end
        @(posedge clk); #1;
        tests++; if (RD1D !== 32'h0) begin fails++; $display("FAIL reset_x5_after got %h expected %h", RD1D, 32'h0); end
    endtask

    task automatic test_result_mux();
        logic [31:0] exp_v [4];
        exp_v[0] = 32'h11; exp_v[1] = 32'h22; exp_v[2] = 32'h33; exp_v[3] = 32'h44;
        @(negedge clk);
        RegWriteW = 1'b0;
        ALUResultW = 32'h11; ReadDataW = 32'h22; PCPlus4W = 32'h33; ImmExtW = 32'h44;
        for (int i = 0; i < 4; i++) begin
            ResultSrcW = 2'(i);
            #1;
            tests++;
            if (ResultW !== exp_v[i]) begin
                fails++; $display("FAIL mux_sel%0d got %h expected %h", i, ResultW, exp_v[i]);
            end
        end
    endtask

    task automatic test_commit_bypass();
        @(negedge clk);
        RegWriteW = 1'b1; RdW = 5'd7; ResultSrcW = 2'b01; ReadDataW = 32'h12345678;
        A1D = 5'd7; A2D = 5'd7;
        #1;
        tests++; if (RD1D !== 32'h12345678) begin fails++; $display("FAIL bypass_rd1 got %h expected %h", RD1D, 32'h12345678); end
        tests++; if (RD2D !== 32'h12345678) begin fails++; $display("FAIL bypass_rd2 got %h expected %h", RD2D, 32'h12345678); end
        @(negedge clk);
        RegWriteW = 1'b0; ReadDataW = 32'h0;
        #1;
        tests++; if (RD1D !== 32'h12345678) begin fails++; $display("FAIL stored_rd1 got %h expected %h", RD1D, 32'h12345678); end
        tests++; if (RD2D !== 32'h12345678) begin fails++; $display("FAIL stored_rd2 got %h expected %h", RD2D, 32'h12345678); end
        // Top index, written through the PC+4 path.
        RegWriteW = 1'b1; RdW = 5'd31; ResultSrcW = 2'b10; PCPlus4W = 32'hCAFE0004;
        @(negedge clk);
        RegWriteW = 1'b0; PCPlus4W = 32'h0; A2D = 5'd31;
        #1;
        tests++; if (RD2D !== 32'hCAFE0004) begin fails++; $display("FAIL stored_x31 got %h expected %h", RD2D, 32'hCAFE0004); end
        tests++; if (RD1D !== 32'h12345678) begin fails++; $display("FAIL x7_untouched got %h expected %h", RD1D, 32'h12345678); end
    endtask

    task automatic test_x0();
        @(negedge clk);
        RegWriteW = 1'b1; RdW = 5'd0; ResultSrcW = 2'b00; ALUResultW = 32'hFFFFFFFF; A1D = 5'd0;
        #1;
        tests++; if (RD1D !== 32'h0) begin fails++; $display("FAIL x0_same_cycle got %h expected %h", RD1D, 32'h0); end
        @(posedge clk); #1;
        RegWriteW = 1'b0;
        #1;
        tests++; if (RD1D !== 32'h0) begin fails++; $display("FAIL x0_after_edge got %h expected %h", RD1D, 32'h0); end
    endtask

    task automatic test_a0();
        @(negedge clk);
        RegWriteW = 1'b1; RdW = 5'd10; ResultSrcW = 2'b11; ImmExtW = 32'h0000002A; A1D = 5'd10;
        @(posedge clk); #1;
        tests++; if (a0 !== 32'h2A) begin fails++; $display("FAIL a0_load got %h expected %h", a0, 32'h2A); end
        @(negedge clk);
        RdW = 5'd11; ImmExtW = 32'h00000099; A2D = 5'd11;
        @(posedge clk); #1;
        tests++; if (a0 !== 32'h2A) begin fails++; $display("FAIL a0_hold got %h expected %h", a0, 32'h2A); end
        @(negedge clk);
        RegWriteW = 1'b0;
        #1;
        tests++; if (RD2D !== 32'h99) begin fails++; $display("FAIL x11_stored got %h expected %h", RD2D, 32'h99); end
        #1 rst = 1'b0;
        #1;
        tests++; if (a0 !== 32'h0) begin fails++; $display("FAIL a0_async_reset got %h expected %h", a0, 32'h0); end
        tests++; if (RD1D !== 32'h0) begin fails++; $display("FAIL x10_async_reset got %h expected %h", RD1D, 32'h0); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        RegWriteW = 1'b1; RdW = 5'd3; ResultSrcW = 2'b00; ALUResultW = 32'd1; A2D = 5'd3;
        #1;
        tests++; if (RD2D !== 32'd1) begin fails++; $display("FAIL b2b_first got %h expected %h", RD2D, 32'd1); end
        @(negedge clk);
        ALUResultW = 32'd2;
        #1;
        tests++; if (RD2D !== 32'd2) begin fails++; $display("FAIL b2b_second got %h expected %h", RD2D, 32'd2); end
        RegWriteW = 1'b0;
        #1;
        tests++; if (RD2D !== 32'd1) begin fails++; $display("FAIL b2b_stored_first got %h expected %h", RD2D, 32'd1); end
        RegWriteW = 1'b1;
        @(negedge clk);
        RegWriteW = 1'b0; ALUResultW = 32'd0;
        #1;
        tests++; if (RD2D !== 32'd2) begin fails++; $display("FAIL b2b_last_wins got %h expected %h", RD2D, 32'd2); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_result_mux();
        test_commit_bypass();
        test_x0();
        test_a0();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
